sdram_responder: RTL and testbench
==================================

# sdram_responder

Memory-side responder for the cache controller's SDRAM interface. It accepts a line request on `mstrb_sdram`, waits a fixed access latency, then streams one cache line of 32 bytes: out of its backing store for a read (line fill), or into it for a write (dirty writeback). It sits in `cache_top` opposite the cache controller and serves as both the synthesizable memory model and the behavioural reference for the SDRAM end of the protocol.

## Interface
- `ADDR_WIDTH`, 16: byte address width.
- `DATA_WIDTH`, 8: beat width.
- `OFFSET_SIZE`, 5: line offset bits; line is 2**OFFSET_SIZE beats.
- `ACCESS_LAT`, 4: cycles from request capture to first beat; legal range is 1 or more.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `Address_sdram` in ADDR_WIDTH: request address; offset bits ignored.
- `wr_rd_sdram` in 1: 1 = write line to memory, 0 = read line.
- `mstrb_sdram` in 1: one-cycle request strobe.
- `Din_sdram` in DATA_WIDTH: write data from cache SRAM.
- `Dout_sdram` out DATA_WIDTH: read data, registered.
- `beat_sdram` out 1: beat active this cycle.
- `beat_idx_sdram` out OFFSET_SIZE: byte offset of current beat.
- `busy_sdram` out 1: high in every non-IDLE state.
- `done_sdram` out 1: one-cycle completion pulse.
- `err_sdram` out 1: sticky protocol error (see Configuration).

## Operation
- States: IDLE, WAIT, XFER, WTAIL, DONE.
- **IDLE**
  - `mstrb_sdram`=1 latches `base = {Address_sdram[ADDR_WIDTH-1:OFFSET_SIZE], 0}` and `wr_rd_sdram`.
  - Latency counter loads ACCESS_LAT-1; next state is WAIT.
- **WAIT**: counter decrements; when it reaches 0, idx clears to 0 and the next state is XFER.
- **XFER**: `beat_sdram`=1 and `beat_idx_sdram`=idx, with idx incrementing 0..31, one beat per cycle.
  - Read: `Dout_sdram` = mem[base+idx] in the same cycle as the beat.
  - Write: the cache drives `Din_sdram` for beat k in the cycle after beat k. The responder writes mem[base+k] at the edge that ends that cycle.
  - After idx 31: a read goes to DONE; a write goes to WTAIL.
- **WTAIL**: one cycle, no beat; captures byte 31; next state is DONE.
- **DONE**: `done_sdram`=1 for one cycle; next state is IDLE.
- Address arithmetic: base+idx never carries out of the offset field, so a line never wraps into the next line or past the top of memory.
- `mstrb_sdram` in any non-IDLE state (DONE included) is ignored; the transfer proceeds unchanged.
- Backing store holds 2**ADDR_WIDTH bytes and is not cleared by reset. Simulation initial contents: mem[a] = a[7:0].
- Reset mid-operation:
  - The next cycle is IDLE with all outputs 0.
  - Bytes already committed stay written; uncommitted beats are dropped.
- Reset values: `Dout_sdram`=0, `beat_sdram`=0, `beat_idx_sdram`=0, `busy_sdram`=0, `done_sdram`=0, `err_sdram`=0.

## Timing
- Strobe sampled at edge of cycle T; `busy_sdram` rises in T+1.
- WAIT occupies T+1..T+ACCESS_LAT.
- Beats occur in T+ACCESS_LAT+1..T+ACCESS_LAT+32.
- Read: `done_sdram` in T+ACCESS_LAT+33.
- Write: WTAIL in T+ACCESS_LAT+33; `done_sdram` in T+ACCESS_LAT+34.
- `busy_sdram` falls the cycle after DONE. A strobe in that cycle is accepted, giving a back-to-back gap of 0 idle cycles.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `SDRAM_PROTO_CHK_EN` defined:
  - A strobe while `busy_sdram`=1 sets `err_sdram`.
  - `err_sdram` stays set until `rst`.
- Not defined: `err_sdram` is tied to 0 and the check logic is absent.
- Transfer behaviour is identical in both builds.

## Structure
- Package `sdram_pkg` holds:
  - the state enum `sdram_state_t` (IDLE, WAIT, XFER, WTAIL, DONE);
  - `LINE_BYTES`;
  - the WR/RD encoding constants.
- Sub-module `sdram_mem_array`: byte array with one write port and one read port, plus the simulation initial pattern. The FSM, counters and address formation live in `sdram_responder`.

## Test plan
- Read line fill:
  - Stimulus: after reset, ACCESS_LAT=4, read at 0x1234 in T.
  - Response: beats in T+5..T+36 with idx 0..31 and `Dout_sdram` 0x20..0x3F; `done_sdram` in T+37 only.
- Writeback then readback:
  - Stimulus: write line 0xABC0 with beat k data = 0xFF-k, then read 0xABDF.
  - Response: readback returns 0xFF..0xE0.
  - Write `done_sdram` lands at T+38.
- Protocol check:
  - Stimulus: strobe during WAIT and again during DONE.
  - Response: the first transfer completes unchanged and no new transfer starts.
  - `err_sdram`=1 with `SDRAM_PROTO_CHK_EN` defined; 0 without it.
- Reset mid-write:
  - Stimulus: `rst` asserted during the beat-10 cycle of a write to 0x4000.
  - Response: all outputs 0 next cycle.
  - Bytes 0x4000..0x4008 hold new data; 0x4009..0x401F keep their old values.
- Top of memory:
  - Stimulus: read at 0xFFFF.
  - Response: base 0xFFE0, data 0xE0..0xFF, no access to 0x0000.
- Back-to-back:
  - Stimulus: ACCESS_LAT=1, second strobe in the first cycle after `done_sdram`.
  - Response: accepted, with its first beat 2 cycles later.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared types and constants for the SDRAM line responder.
package sdram_pkg;

    // Responder control states
    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        XFER,
        WTAIL,
        DONE
    } sdram_state_t;

    // Bytes per cache line (one beat per byte)
    localparam int unsigned LINE_BYTES = 32;

    // wr_rd_sdram encoding
    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

endpackage

// File: rtl/sdram_mem_array.sv
// sdram_mem_array: byte-wide backing store, one write port, one asynchronous
// read port. Contents are not affected by reset; the power-up image holds the
// low address byte at every location (mem[a] = a[7:0]).
module sdram_mem_array
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

    function automatic mem_t init_pattern();
        mem_t m;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            m[a] = DATA_WIDTH'(a[7:0]);
        end
        return m;
    endfunction

    mem_t mem = init_pattern();

    // Single write port, committed on the rising edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: memory-side responder streaming one cache line per request
// after a fixed access latency. Optional protocol checking is compiled in when
// SDRAM_PROTO_CHK_EN is defined; otherwise err_sdram is tied low.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned OFFSET_SIZE = 5,
    parameter int unsigned ACCESS_LAT  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  Address_sdram,
    input  logic                   wr_rd_sdram,
    input  logic                   mstrb_sdram,
    input  logic [DATA_WIDTH-1:0]  Din_sdram,
    output logic [DATA_WIDTH-1:0]  Dout_sdram,
    output logic                   beat_sdram,
    output logic [OFFSET_SIZE-1:0] beat_idx_sdram,
    output logic                   busy_sdram,
    output logic                   done_sdram,
    output logic                   err_sdram
);

    localparam int unsigned LINE_W = ADDR_WIDTH - OFFSET_SIZE;
    localparam int unsigned CNT_W  = $clog2(ACCESS_LAT + 1);
    localparam logic [OFFSET_SIZE-1:0] LAST_IDX = '1;

    sdram_state_t           state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OFFSET_SIZE-1:0] idx_q, idx_d;
    logic [LINE_W-1:0]      line_q, line_d;
    logic                   wr_q, wr_d;
    logic                   wpend_q, wpend_d;
    logic [OFFSET_SIZE-1:0] widx_q, widx_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                   beat_q, beat_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [ADDR_WIDTH-1:0]  mem_raddr;
    logic [ADDR_WIDTH-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic                   mem_we;

    logic unused_offset;
    assign unused_offset = ^Address_sdram[OFFSET_SIZE-1:0];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            line_q  <= '0;
            wr_q    <= RD;
            wpend_q <= 1'b0;
            widx_q  <= '0;
            dout_q  <= '0;
            beat_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
            wr_q    <= wr_d;
            wpend_q <= wpend_d;
            widx_q  <= widx_d;
            dout_q  <= dout_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counters and registered-output precompute
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        line_d  = line_q;
        wr_d    = wr_q;
        wpend_d = 1'b0;
        widx_d  = widx_q;

        unique case (state_q)
            IDLE: begin
                if (mstrb_sdram) begin
                    line_d  = Address_sdram[ADDR_WIDTH-1:OFFSET_SIZE];
                    wr_d    = wr_rd_sdram;
                    cnt_d   = CNT_W'(ACCESS_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    idx_d   = '0;
                    state_d = XFER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            XFER: begin
                idx_d = idx_q + 1'b1;
                // Write data for this beat arrives next cycle; remember which byte.
                if (wr_q == WR) begin
                    wpend_d = 1'b1;
                    widx_d  = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = (wr_q == WR) ? WTAIL : DONE;
                end
            end
            WTAIL: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        beat_d = (state_d == XFER);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        dout_d = (state_d == XFER && wr_q == RD) ? mem_rdata : '0;
    end

    // Line address is concatenated, never added, so beats cannot leave the line.
    assign mem_raddr = {line_q, idx_d};
    assign mem_waddr = {line_q, widx_q};
    assign mem_we    = wpend_q && !rst;

    sdram_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (Din_sdram),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign Dout_sdram     = dout_q;
    assign beat_sdram     = beat_q;
    assign beat_idx_sdram = idx_q;
    assign busy_sdram     = busy_q;
    assign done_sdram     = done_q;

`ifdef SDRAM_PROTO_CHK_EN
    logic err_q, err_d;

    // Sticky flag for a strobe arriving while a transfer is in progress
    always_comb begin
        err_d = err_q | (mstrb_sdram & busy_q);
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sdram = err_q;
`else
    assign err_sdram = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: scoreboard bench for sdram_responder (two instances,
// ACCESS_LAT=4 and ACCESS_LAT=1).
module tb_sdram_responder;
    import sdram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   = 1'b1;
    logic        mstrb = 1'b0;
    logic        wr    = 1'b0;
    logic        sel   = 1'b0;
    logic [15:0] addr  = '0;
    logic [7:0]  din   = '0;

    logic [7:0] dout0, dout1;
    logic       beat0, beat1, busy0, busy1, done0, done1, err0, err1;
    logic [4:0] idx0, idx1;

    logic [7:0] o_dout;
    logic       o_beat, o_busy, o_done, o_err;
    logic [4:0] o_idx;

    sdram_responder #(
        .ADDR_WIDTH (16), .DATA_WIDTH (8), .OFFSET_SIZE (5), .ACCESS_LAT (4)
    ) dut (
        .clk (clk), .rst (rst), .Address_sdram (addr), .wr_rd_sdram (wr),
        .mstrb_sdram (mstrb & ~sel), .Din_sdram (din), .Dout_sdram (dout0),
        .beat_sdram (beat0), .beat_idx_sdram (idx0), .busy_sdram (busy0),
        .done_sdram (done0), .err_sdram (err0)
    );

    sdram_responder #(
        .ADDR_WIDTH (16), .DATA_WIDTH (8), .OFFSET_SIZE (5), .ACCESS_LAT (1)
    ) dut1 (
        .clk (clk), .rst (rst), .Address_sdram (addr), .wr_rd_sdram (wr),
        .mstrb_sdram (mstrb & sel), .Din_sdram (din), .Dout_sdram (dout1),
        .beat_sdram (beat1), .beat_idx_sdram (idx1), .busy_sdram (busy1),
        .done_sdram (done1), .err_sdram (err1)
    );

    assign o_dout = sel ? dout1 : dout0;
    assign o_beat = sel ? beat1 : beat0;
    assign o_idx  = sel ? idx1  : idx0;
    assign o_busy = sel ? busy1 : busy0;
    assign o_done = sel ? done1 : done0;
    assign o_err  = sel ? err1  : err0;

    typedef struct packed {
        logic [4:0] idx;
        logic [7:0] data;
        logic       chk;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] model [logic [15:0]];
    int         checks   = 0;
    int         failures = 0;

`ifdef SDRAM_PROTO_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    function automatic logic [7:0] model_rd(input logic [15:0] a);
        if (model.exists(a)) return model[a];
        return a[7:0];
    endfunction

    // One line transfer starting (strobe) in the current cycle. Write beat k
    // carries 0xFF-k. abort_at>0 asserts rst during that relative cycle.
    task automatic run_xfer(input bit w, input logic [15:0] a, input int lat,
                            input bit extra, input int abort_at);
        logic [15:0] base;
        int          n;
        int          last;
        exp_t        e;
        base = {a[15:5], 5'd0};
        n    = lat + 33 + (w ? 1 : 0);
        last = (abort_at > 0) ? abort_at + 1 : n;
        for (int k = 0; k < 32; k++) begin
            e.idx  = 5'(k);
            e.chk  = !w;
            e.data = w ? 8'h00 : model_rd(base + 16'(k));
            sbq.push_back(e);
        end
        addr = a;
        wr   = w;
        for (int c = 0; c <= last; c++) begin
            mstrb = (c == 0) || (extra && (c == 2 || c == n));
            rst   = (abort_at > 0 && c == abort_at);
            if (w && c >= lat + 2 && c <= lat + 33) begin
                din = 8'hFF - 8'(c - lat - 2);
                if (!(abort_at > 0 && c >= abort_at))
                    model[base + 16'(c - lat - 2)] = din;
            end
            @(negedge clk);
            checks++;
            if (abort_at > 0 && c == abort_at + 1) begin
                if ({o_dout, o_beat, o_idx, o_busy, o_done, o_err} !== '0) begin
                    failures++;
                    $display("FAIL after_reset a=%h got dout=%h beat=%b idx=%0d busy=%b done=%b err=%b exp all 0",
                             a, o_dout, o_beat, o_idx, o_busy, o_done, o_err);
                end
            end else if (c == 0) begin
                if (o_busy !== 1'b0 || o_beat !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_before a=%h got busy=%b beat=%b exp 0 0", a, o_busy, o_beat);
                end
            end else if (c <= lat) begin
                if (o_busy !== 1'b1 || o_beat !== 1'b0 || o_done !== 1'b0) begin
                    failures++;
                    $display("FAIL wait_phase a=%h c=%0d got busy=%b beat=%b done=%b exp 1 0 0",
                             a, c, o_busy, o_beat, o_done);
                end
            end else if (c <= lat + 32) begin
                if (o_beat !== 1'b1 || sbq.size() == 0) begin
                    failures++;
                    $display("FAIL beat_present a=%h c=%0d got beat=%b exp 1", a, c, o_beat);
                end else begin
                    e = sbq.pop_front();
                    if (o_idx !== e.idx || (e.chk && o_dout !== e.data)) begin
                        failures++;
                        $display("FAIL beat_data a=%h c=%0d got idx=%0d dout=%h exp idx=%0d dout=%h",
                                 a, c, o_idx, o_dout, e.idx, e.data);
                    end
                end
            end else if (c < n) begin
                if (o_busy !== 1'b1 || o_beat !== 1'b0 || o_done !== 1'b0) begin
                    failures++;
                    $display("FAIL wtail a=%h got busy=%b beat=%b done=%b exp 1 0 0",
                             a, o_busy, o_beat, o_done);
                end
            end else begin
                if (o_done !== 1'b1 || o_busy !== 1'b1 || o_beat !== 1'b0) begin
                    failures++;
                    $display("FAIL done_pulse a=%h c=%0d got done=%b busy=%b beat=%b exp 1 1 0",
                             a, c, o_done, o_busy, o_beat);
                end
            end
            @(posedge clk);
            #1;
        end
        mstrb = 1'b0;
        rst   = 1'b0;
        if (abort_at > 0) begin
            sbq.delete();
        end else begin
            checks++;
            if (sbq.size() != 0) begin
                failures++;
                $display("FAIL beat_count a=%h got %0d missing beats exp 0", a, sbq.size());
                sbq.delete();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if ({dout0, beat0, idx0, busy0, done0, err0} !== '0) begin
            failures++;
            $display("FAIL reset_dut0 got dout=%h beat=%b idx=%0d busy=%b done=%b err=%b exp all 0",
                     dout0, beat0, idx0, busy0, done0, err0);
        end
        checks++;
        if ({dout1, beat1, idx1, busy1, done1, err1} !== '0) begin
            failures++;
            $display("FAIL reset_dut1 got dout=%h beat=%b idx=%0d busy=%b done=%b err=%b exp all 0",
                     dout1, beat1, idx1, busy1, done1, err1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_read_fill();
        sel = 1'b0;
        run_xfer(1'b0, 16'h1234, 4, 1'b0, 0);
    endtask

    task automatic test_writeback();
        sel = 1'b0;
        run_xfer(1'b1, 16'hABC0, 4, 1'b0, 0);
        run_xfer(1'b0, 16'hABDF, 4, 1'b0, 0);
    endtask

    task automatic test_top_of_memory();
        sel = 1'b0;
        run_xfer(1'b0, 16'hFFFF, 4, 1'b0, 0);
    endtask

    task automatic test_reset_mid_write();
        sel = 1'b0;
        run_xfer(1'b1, 16'h4000, 4, 1'b0, 4 + 1 + 10);
        run_xfer(1'b0, 16'h4000, 4, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        run_xfer(1'b0, 16'h0100, 1, 1'b0, 0);
        run_xfer(1'b0, 16'h0230, 1, 1'b0, 0);
        sel = 1'b0;
    endtask

    task automatic test_protocol();
        sel = 1'b0;
        run_xfer(1'b0, 16'h2000, 4, 1'b1, 0);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (o_busy !== 1'b0 || o_err !== EXP_ERR) begin
                failures++;
                $display("FAIL proto_after got busy=%b err=%b exp busy=0 err=%b", o_busy, o_err, EXP_ERR);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_read_fill();
        test_writeback();
        test_top_of_memory();
        test_reset_mid_write();
        test_back_to_back();
        test_protocol();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
